pair_event_counter: RTL

//   Downstream consumer of the pair detector's registered 'detect' output.

---
 rtl/pair_event_counter.sv | 97 +++++++++
 1 files changed

// File: rtl/pair_event_counter.sv
// Counts pair-detector 'detect' pulses over back-to-back windows of WINDOW cycles
// and reports each window's (saturating) count with a one-cycle strobe plus an alarm level.
module pair_event_counter #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             detect,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             alarm,
    output logic             busy,
    output logic             state_dbg
);

    localparam int WC_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WC_W-1:0]  LAST    = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WC_W-1:0]  win_cnt, win_cnt_nx;
    logic [CNT_W-1:0] acc, acc_nx, acc_inc;
    logic [CNT_W-1:0] count_nx;
    logic             alarm_nx, valid_nx;

    // count_valid is a pure strobe with no ready: the consumer must capture
    // count_out/alarm in the single cycle count_valid is high; nothing back-pressures.

    assign acc_inc = (detect && (acc != ACC_MAX)) ? acc + CNT_W'(1) : acc;

    always_comb begin
        state_nx   = state;
        win_cnt_nx = win_cnt;
        acc_nx     = acc;
        count_nx   = count_out;
        alarm_nx   = alarm;
        valid_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx   = RUN;
                    win_cnt_nx = '0;
                    acc_nx     = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    // Abort beats the report even on the last sampled cycle.
                    state_nx   = IDLE;
                    win_cnt_nx = '0;
                    acc_nx     = '0;
                end else if (win_cnt == LAST) begin
                    count_nx   = acc_inc;
                    alarm_nx   = (acc_inc >= THR);
                    valid_nx   = 1'b1;
                    win_cnt_nx = '0;
                    acc_nx     = '0;
                end else begin
                    acc_nx     = acc_inc;
                    win_cnt_nx = win_cnt + WC_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            win_cnt     <= '0;
            acc         <= '0;
            count_out   <= '0;
            alarm       <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            win_cnt     <= win_cnt_nx;
            acc         <= acc_nx;
            count_out   <= count_nx;
            alarm       <= alarm_nx;
            count_valid <= valid_nx;
        end
    end

    assign busy      = (state == RUN);
    assign state_dbg = state;

endmodule
